// File: rtl/game_sec_timer_if.sv
// Control and status bundle between the game sequencer and the seconds/round timer.
// master drives start/pause and observes status; slave is the timer itself.
interface game_sec_timer_if;
   logic       start;
   logic       pause;
   logic [7:0] sec;
   logic [3:0] round;
   logic       running;
   logic       round_done;
   logic       game_over;

   modport master (
      output start,
      output pause,
      input  sec,
      input  round,
      input  running,
      input  round_done,
      input  game_over
   );

   modport slave (
      input  start,
      input  pause,
      output sec,
      output round,
      output running,
      output round_done,
      output game_over
   );
endinterface

// File: rtl/game_sec_timer.sv
// Per-round seconds counter and round sequencer for the game, clocked at 1 Hz.
// Sequences rounds, handles pause, and flags round completion and game over.
module game_sec_timer #(
   parameter int unsigned ROUND_LEN  = 30,
   parameter int unsigned NUM_ROUNDS = 3
) (
   input  logic             clk_1hz,
   input  logic             rst,
   game_sec_timer_if.slave  bus
);

   localparam logic [7:0] LAST_SEC   = 8'(ROUND_LEN);
   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      PAUSED,
      ROUND_END,
      GAME_OVER
   } state_t;

   state_t state;

   // NOTE: every register here uses <= so all state updates see the pre-edge values.
   always_ff @(posedge clk_1hz) begin
      if (rst) begin
         state          <= IDLE;
         bus.sec        <= '0;
         bus.round      <= '0;
         bus.running    <= 1'b0;
         bus.round_done <= 1'b0;
         bus.game_over  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // start wins over pause; pause is first looked at once in RUN
               if (bus.start) begin
                  state       <= RUN;
                  bus.sec     <= '0;
                  bus.round   <= 4'd1;
                  bus.running <= 1'b1;
               end
            end

            RUN: begin
               // round end outranks pause so the final second is never frozen
               if (bus.sec == LAST_SEC) begin
                  state          <= ROUND_END;
                  bus.round_done <= 1'b1;
                  bus.running    <= 1'b0;
               end else if (bus.pause) begin
                  state       <= PAUSED;
                  bus.running <= 1'b0;
               end else begin
                  bus.sec <= bus.sec + 8'd1;
               end
            end

            PAUSED: begin
               if (!bus.pause) begin
                  state       <= RUN;
                  bus.running <= 1'b1;
               end
            end

            ROUND_END: begin
               bus.round_done <= 1'b0;
               if (bus.round == LAST_ROUND) begin
                  state         <= GAME_OVER;
                  bus.game_over <= 1'b1;
               end else begin
                  state       <= RUN;
                  bus.round   <= bus.round + 4'd1;
                  bus.sec     <= '0;
                  bus.running <= 1'b1;
               end
            end

            GAME_OVER: begin
               if (bus.start) begin
                  state         <= RUN;
                  bus.sec       <= '0;
                  bus.round     <= 4'd1;
                  bus.game_over <= 1'b0;
                  bus.running   <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
